// File: rtl/clause_loader_pkg.sv
// Shared widths, the no-write address and the state encoding for the clause-register loader.
package clause_loader_pkg;

    localparam logic [1:0] IDLE_ENC   = 2'd0;
    localparam logic [1:0] LOAD_ENC   = 2'd1;
    localparam logic [1:0] FINISH_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = IDLE_ENC,
        LOAD   = LOAD_ENC,
        FINISH = FINISH_ENC
    } state_e;

    // One clause word carries 2**vi_w variable coefficients plus the bias.
    function automatic int clause_word_width(input int coef_w, input int vi_w);
        return ((2 ** vi_w) + 1) * coef_w;
    endfunction

    function automatic int index_width(input int ci_w);
        return ci_w + 1;
    endfunction

    function automatic int no_write_index(input int ci_w);
        return 2 ** ci_w;
    endfunction

endpackage

// File: rtl/clause_loader.sv
// Streams clause words into the clause registers one per cycle, then parks the index on the
// no-write address, publishes the reduce-enable mask and pulses done.
module clause_loader
    import clause_loader_pkg::*;
#(
    parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 8,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
    parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 3,
    localparam int WORD_W = clause_word_width(MAXIMUM_BIT_WIDTH_OF_COEFFICIENT,
                                              MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX),
    localparam int IDX_W  = index_width(MAX_BIT_WIDTH_OF_CLAUSES_INDEX),
    localparam int NC     = no_write_index(MAX_BIT_WIDTH_OF_CLAUSES_INDEX)
) (
    input  logic              in_clk,
    input  logic              in_reset_n,
    input  logic              in_start,
    input  logic [IDX_W-1:0]  in_clause_count,
    input  logic [WORD_W-1:0] in_clause_coefficients,
    input  logic              in_clause_valid,
    input  logic              in_clause_last,
    output logic              out_clause_ready,
    output logic [WORD_W-1:0] out_clause_coefficients,
    output logic [IDX_W-1:0]  out_clause_index,
    output logic [NC-1:0]     out_reduce_enable,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_error
);

    localparam int CI_W = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam logic [IDX_W-1:0] NO_WRITE = IDX_W'(NC);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [WORD_W-1:0]   coef_q, coef_d;
    logic [NC-1:0]       mask_q, mask_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                handshake;
    logic [IDX_W-1:0]    wr_cnt_next;
    logic [IDX_W-1:0]    count_sat;

    assign out_clause_ready = (state_q == LOAD);
    assign handshake        = in_clause_valid && out_clause_ready;
    assign wr_cnt_next      = wr_cnt_q + IDX_W'(1);
    // Requests above the register count load every register once and stop.
    assign count_sat        = (in_clause_count > NO_WRITE) ? NO_WRITE : in_clause_count;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_cnt_d = wr_cnt_q;
        index_d  = NO_WRITE;
        coef_d   = coef_q;
        mask_d   = mask_q;
        done_d   = 1'b0;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    count_d  = count_sat;
                    wr_cnt_d = '0;
                    mask_d   = '0;
                    error_d  = 1'b0;
                    state_d  = (count_sat == '0) ? FINISH : LOAD;
                end
            end
            LOAD: begin
                // Without a handshake the index falls back to NO_WRITE so no register is rewritten.
                if (handshake) begin
                    index_d  = wr_cnt_q;
                    coef_d   = in_clause_coefficients;
                    mask_d[wr_cnt_q[CI_W-1:0]] = 1'b1;
                    wr_cnt_d = wr_cnt_next;
                    if ((wr_cnt_next == count_q) || in_clause_last) begin
                        state_d = FINISH;
                    end
                    if (in_clause_last && (wr_cnt_next < count_q)) begin
                        error_d = 1'b1;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            wr_cnt_q <= '0;
            index_q  <= NO_WRITE;
            coef_q   <= '0;
            mask_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_cnt_q <= wr_cnt_d;
            index_q  <= index_d;
            coef_q   <= coef_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign out_clause_coefficients = coef_q;
    assign out_clause_index        = index_q;
    assign out_reduce_enable       = mask_q;
    assign out_busy                = (state_q != IDLE);
    assign out_done                = done_q;
    assign out_error               = error_q;

endmodule
